// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// Module   : display_scan
// Purpose  : Time-multiplexed 8-digit 7-segment scanner with per-slot
//            blanking, frame-level shadowing of display data, lamp test and
//            a frame wrap pulse. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] led0,
  input  logic [6:0] led1,
  input  logic [6:0] led2,
  input  logic [6:0] led3,
  input  logic [6:0] led4,
  input  logic [6:0] led5,
  input  logic [6:0] led6,
  input  logic [6:0] led7,
  input  logic [7:0] digit_en,
  input  logic [7:0] dp_mask,
  input  logic       lamp_test,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int                CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEAD    = CNT_W'(DEAD_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [6:0]       led_sh [8];
  logic [7:0]       en_sh;
  logic [7:0]       dp_sh;

  logic             cnt_wrap;
  logic             capture;
  logic             blank;
  logic [7:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;
  logic             tick_d;

  assign cnt_wrap = (cnt == CNT_MAX);
  assign capture  = (idx == 3'd0) && (cnt == '0);
  assign blank    = (cnt < DEAD);

  // Slot counter and digit index; index advances on each slot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame shadow: latch display data once per frame so a frame never tears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) led_sh[i] <= 7'h7F;
      en_sh <= 8'h00;
      dp_sh <= 8'h00;
    end else if (capture) begin
      led_sh[0] <= led0;
      led_sh[1] <= led1;
      led_sh[2] <= led2;
      led_sh[3] <= led3;
      led_sh[4] <= led4;
      led_sh[5] <= led5;
      led_sh[6] <= led6;
      led_sh[7] <= led7;
      en_sh     <= digit_en;
      dp_sh     <= dp_mask;
    end
  end

  // Next output values; lamp test is live and overrides the digit enable,
  // but the blanking window always wins so anodes never overlap.
  always_comb begin
    an_d   = 8'hFF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    tick_d = (idx == 3'd7) && cnt_wrap;
    if (!blank) begin
      if (lamp_test) begin
        an_d  = ~(8'd1 << idx);
        seg_d = 7'h00;
        dp_d  = 1'b0;
      end else if (en_sh[idx]) begin
        an_d  = ~(8'd1 << idx);
        seg_d = led_sh[idx];
        dp_d  = ~dp_sh[idx];
      end
    end
  end

  // Output registers (one cycle behind the counter state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp_n       <= dp_d;
      frame_tick <= tick_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan
// Purpose  : Self-checking bench for display_scan (SCAN_DIV=8, DEAD_CYCLES=2).
//            Cycle N is the value visible after the N-th rising edge
//            following reset release (edge 0 is the first released edge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] led0, led1, led2, led3, led4, led5, led6, led7;
  logic [7:0] digit_en, dp_mask;
  logic       lamp_test;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp_n;
  logic       frame_tick;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int         scen;
    int         lo;
    int         hi;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp_n;
  } vec_t;

  vec_t vecs[$];
  bit   tick_q[$];

  display_scan #(.SCAN_DIV(8), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .led0(led0), .led1(led1), .led2(led2), .led3(led3),
    .led4(led4), .led5(led5), .led6(led6), .led7(led7),
    .digit_en(digit_en), .dp_mask(dp_mask), .lamp_test(lamp_test),
    .an(an), .seg(seg), .dp_n(dp_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    else passed++;
  endtask

  task automatic add(input int s, input int lo, input int hi, input logic [7:0] a, input logic [6:0] sg, input logic d);
    vec_t v;
    v.scen = s; v.lo = lo; v.hi = hi; v.an = a; v.seg = sg; v.dp_n = d;
    vecs.push_back(v);
  endtask

  task automatic setup(input logic [7:0] en, input logic [7:0] dp, input logic lt);
    led0 = 7'h40; led1 = 7'h79; led2 = 7'h7F; led3 = 7'h7F;
    led4 = 7'h7F; led5 = 7'h7F; led6 = 7'h7F; led7 = 7'h7F;
    digit_en = en; dp_mask = dp; lamp_test = lt;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Each iteration: edge c-1 occurs, inputs for edge c are driven, then
  // cycle c is sampled on the falling edge.
  task automatic run(input int s, input int ncyc);
    int  base;
    int  fc;
    bit  exp_tick;
    base = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      if (s == 1 && c == 5)  led0 = 7'h24;
      if (s == 4 && c == 20) rst_n = 1'b0;
      if (s == 4 && c == 21) begin
        rst_n = 1'b1;
        base  = 21;
      end
      fc = c - base;
      tick_q.push_back((fc > 0) && (fc % 64 == 0));
      @(negedge clk);
      if (tick_q.size() == 0) begin
        total++;
        $display("FAIL tick_queue cycle %0d: got empty expected entry", c);
      end else begin
        exp_tick = tick_q.pop_front();
        check("frame_tick", c, {7'd0, frame_tick}, {7'd0, exp_tick});
      end
      total++;
      if (an != 8'hFF && $countones(~an) != 1)
        $display("FAIL an_onehot cycle %0d: got %h expected at most one low bit", c, an);
      else passed++;
      foreach (vecs[i]) begin
        if (vecs[i].scen == s && c >= vecs[i].lo && c <= vecs[i].hi) begin
          check("an",   c, an,              vecs[i].an);
          check("seg",  c, {1'b0, seg},     {1'b0, vecs[i].seg});
          check("dp_n", c, {7'd0, dp_n},    {7'd0, vecs[i].dp_n});
        end
      end
    end
  endtask

  initial begin
    // Basic scan, then tear-free update of led0 seen only in the next frame.
    add(1, 1, 2,   8'hFF, 7'h7F, 1'b1);
    add(1, 3, 8,   8'hFE, 7'h40, 1'b1);
    add(1, 9, 10,  8'hFF, 7'h7F, 1'b1);
    add(1, 11, 16, 8'hFD, 7'h79, 1'b1);
    add(1, 65, 66, 8'hFF, 7'h7F, 1'b1);
    add(1, 67, 72, 8'hFE, 7'h24, 1'b1);
    // Disabled digit 0 and decimal point on digit 1.
    add(2, 1, 10,  8'hFF, 7'h7F, 1'b1);
    add(2, 11, 16, 8'hFD, 7'h79, 1'b0);
    // Lamp test overrides digit_en=00 but not the blanking window.
    add(3, 1, 2,   8'hFF, 7'h7F, 1'b1);
    add(3, 3, 8,   8'hFE, 7'h00, 1'b0);
    add(3, 9, 10,  8'hFF, 7'h7F, 1'b1);
    add(3, 11, 16, 8'hFD, 7'h00, 1'b0);
    // Mid-frame reset at edge 20, scan restarts from idx 0.
    add(4, 3, 8,   8'hFE, 7'h40, 1'b1);
    add(4, 21, 23, 8'hFF, 7'h7F, 1'b1);
    add(4, 24, 29, 8'hFE, 7'h40, 1'b1);

    // Reset held with every input active.
    led0 = 7'h00; led1 = 7'h00; led2 = 7'h00; led3 = 7'h00;
    led4 = 7'h00; led5 = 7'h00; led6 = 7'h00; led7 = 7'h00;
    digit_en = 8'hFF; dp_mask = 8'hFF; lamp_test = 1'b1; rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c > 0) begin
        check("rst_an",   c, an,                 8'hFF);
        check("rst_seg",  c, {1'b0, seg},        8'h7F);
        check("rst_dp_n", c, {7'd0, dp_n},       8'h01);
        check("rst_tick", c, {7'd0, frame_tick}, 8'h00);
      end
    end

    setup(8'hFF, 8'h00, 1'b0); run(1, 72);
    setup(8'hFE, 8'h02, 1'b0); run(2, 130);
    setup(8'h00, 8'h00, 1'b1); run(3, 20);
    setup(8'hFF, 8'h00, 1'b0); run(4, 30);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
